// File: rtl/dr_pkg.sv
// -----------------------------------------------------------------------------
// dr_pkg
// Shared definitions for the drinks-machine order front end: default datapath
// widths, the payment saturation limit and the order FSM state type.
// -----------------------------------------------------------------------------
package dr_pkg;

    localparam int PAY_W   = 10;
    localparam int CODE_W  = 8;
    localparam int MAX_PAY = 1023;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT_RSP,
        RESULT
    } dr_ord_state_t;

endpackage

// File: rtl/dr_coin_accum.sv
// -----------------------------------------------------------------------------
// dr_coin_accum
// Saturating coin accumulator. The sum is formed one bit wider than the
// accumulator so that an overflow past ACC_MAX is seen and clamped rather than
// wrapping. Clear has priority over add.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   i_clr     clear the accumulator
//   i_add_en  add i_value this cycle
//   i_value   coin value to add
//   o_acc     current accumulated payment
// -----------------------------------------------------------------------------
module dr_coin_accum
    import dr_pkg::*;
#(
    parameter int ACC_W   = PAY_W,
    parameter int ACC_MAX = MAX_PAY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_add_en,
    input  logic [ACC_W-1:0] i_value,
    output logic [ACC_W-1:0] o_acc
);

    localparam logic [ACC_W:0] LP_MAX = (ACC_W + 1)'(ACC_MAX);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, i_value};

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_add_en) begin
            r_acc <= (w_sum > LP_MAX) ? LP_MAX[ACC_W-1:0] : w_sum[ACC_W-1:0];
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dr_order_builder.sv
// -----------------------------------------------------------------------------
// dr_order_builder
// Customer-side front end of the drinks machine. Collects coins and two keypad
// digits into one order, issues it as a single-cycle valid strobe, waits for
// the machine's verdict and reports the dispensed drink, error or refund.
//
// Optional build macro: DR_RSP_TIMEOUT_EN
//   When defined, an order with no response within RSP_TIMEOUT cycles after
//   valid completes as an error with a full refund. When undefined the FSM
//   waits for a response indefinitely.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   coin_valid/coin_value  coin insertion strobe and value
//   key_valid/key_digit    keypad digit strobe and digit
//   key_ok/key_cancel      confirm / abort the order
//   valid, pay_in, code    order interface to the machine
//   drink, error           machine response
//   coin_reject            pulse: coin inserted while an order was in flight
//   refund, refund_amt     pulse and amount of money to return
//   order_done             pulse: drink_out/err_out updated
//   drink_out, err_out     latched result of the last order
//   busy                   order in ISSUE or WAIT_RSP
// -----------------------------------------------------------------------------
module dr_order_builder #(
    parameter int PAY_W       = dr_pkg::PAY_W,
    parameter int CODE_W      = dr_pkg::CODE_W,
    parameter int MAX_PAY     = dr_pkg::MAX_PAY,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coin_valid,
    input  logic [PAY_W-1:0]  coin_value,
    input  logic              key_valid,
    input  logic [3:0]        key_digit,
    input  logic              key_ok,
    input  logic              key_cancel,
    output logic              valid,
    output logic [PAY_W-1:0]  pay_in,
    output logic [CODE_W-1:0] code,
    input  logic [CODE_W-1:0] drink,
    input  logic              error,
    output logic              coin_reject,
    output logic              refund,
    output logic [PAY_W-1:0]  refund_amt,
    output logic              order_done,
    output logic [CODE_W-1:0] drink_out,
    output logic              err_out,
    output logic              busy
);

    import dr_pkg::*;

    if (RSP_TIMEOUT < 2) begin : g_param_check
        $error("RSP_TIMEOUT must be at least 2");
    end

    dr_ord_state_t     r_state;
    dr_ord_state_t     w_next;
    logic [CODE_W-1:0] r_code;
    logic [1:0]        r_cnt;
    logic              r_coin_reject;
    logic              r_refund;
    logic [PAY_W-1:0]  r_refund_amt;
    logic [CODE_W-1:0] r_drink_out;
    logic              r_err_out;

    logic [PAY_W-1:0]  w_acc;
    logic              w_accept;
    logic              w_cancel;
    logic              w_ok;
    logic              w_rsp;
    logic              w_timeout;
    logic              w_fail;
    logic              w_clr;
    logic              w_add;
    logic              w_dig;

    // Coins and digits are only taken while the order is being assembled;
    // cancel overrides everything else arriving in the same cycle.
    assign w_accept = (r_state == IDLE) || (r_state == COLLECT);
    assign w_cancel = (r_state == COLLECT) && key_cancel;
    assign w_ok     = (r_state == COLLECT) && key_ok && !key_cancel &&
                      (r_cnt == 2'd2) && (w_acc != '0);
    assign w_rsp    = error || (drink != '0);
    assign w_fail   = error || w_timeout;
    assign w_clr    = w_cancel || (r_state == RESULT);
    assign w_add    = w_accept && coin_valid && !w_cancel;
    assign w_dig    = w_accept && key_valid && !w_cancel;

`ifdef DR_RSP_TIMEOUT_EN
    localparam int TO_W = $clog2(RSP_TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Counts WAIT_RSP cycles; value k-1 in the k-th cycle after valid, so the
    // final allowed response cycle is RSP_TIMEOUT-1 and a response there wins.
    always_ff @(posedge clk) begin
        if (rst || (r_state != WAIT_RSP)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_timeout = !w_rsp && (r_to_cnt == TO_W'(RSP_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    dr_coin_accum #(
        .ACC_W   (PAY_W),
        .ACC_MAX (MAX_PAY)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_add_en (w_add),
        .i_value  (coin_value),
        .o_acc    (w_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        valid      = 1'b0;
        busy       = 1'b0;
        order_done = 1'b0;
        pay_in     = '0;
        code       = '0;
        case (r_state)
            IDLE: begin
                if (coin_valid || key_valid) w_next = COLLECT;
            end
            COLLECT: begin
                if (w_cancel)  w_next = IDLE;
                else if (w_ok) w_next = ISSUE;
            end
            ISSUE: begin
                valid  = 1'b1;
                busy   = 1'b1;
                pay_in = w_acc;
                code   = r_code;
                w_next = WAIT_RSP;
            end
            WAIT_RSP: begin
                busy   = 1'b1;
                pay_in = w_acc;
                code   = r_code;
                if (w_rsp || w_timeout) w_next = RESULT;
            end
            RESULT: begin
                order_done = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code        <= '0;
            r_cnt         <= '0;
            r_coin_reject <= 1'b0;
            r_refund      <= 1'b0;
            r_refund_amt  <= '0;
            r_drink_out   <= '0;
            r_err_out     <= 1'b0;
        end else begin
            r_coin_reject <= coin_valid && !w_accept;
            r_refund      <= 1'b0;
            r_refund_amt  <= '0;

            if (w_cancel && (w_acc != '0)) begin
                r_refund     <= 1'b1;
                r_refund_amt <= w_acc;
            end

            // Verdict is latched on the cycle it is seen so it is already
            // valid when order_done pulses in RESULT.
            if ((r_state == WAIT_RSP) && (w_rsp || w_timeout)) begin
                r_err_out   <= w_fail;
                r_drink_out <= w_fail ? '0 : drink;
                if (w_fail) begin
                    r_refund     <= 1'b1;
                    r_refund_amt <= w_acc;
                end
            end

            if (w_clr) begin
                r_code <= '0;
                r_cnt  <= '0;
            end else if (w_dig) begin
                r_code <= {r_code[CODE_W-5:0], key_digit};
                r_cnt  <= (r_cnt == 2'd2) ? 2'd2 : r_cnt + 2'd1;
            end
        end
    end

    assign coin_reject = r_coin_reject;
    assign refund      = r_refund;
    assign refund_amt  = r_refund_amt;
    assign drink_out   = r_drink_out;
    assign err_out     = r_err_out;

endmodule

// File: tb/tb_dr_order_builder.sv
`timescale 1ns/1ps
module tb_dr_order_builder;

    localparam int PAY_W       = 10;
    localparam int CODE_W      = 8;
    localparam int MAX_PAY     = 1023;
    localparam int RSP_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              coin_valid = 1'b0;
    logic [PAY_W-1:0]  coin_value = '0;
    logic              key_valid = 1'b0;
    logic [3:0]        key_digit = '0;
    logic              key_ok = 1'b0;
    logic              key_cancel = 1'b0;
    logic              valid;
    logic [PAY_W-1:0]  pay_in;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] drink = '0;
    logic              error = 1'b0;
    logic              coin_reject;
    logic              refund;
    logic [PAY_W-1:0]  refund_amt;
    logic              order_done;
    logic [CODE_W-1:0] drink_out;
    logic              err_out;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;

    dr_order_builder dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .key_ok      (key_ok),
        .key_cancel  (key_cancel),
        .valid       (valid),
        .pay_in      (pay_in),
        .code        (code),
        .drink       (drink),
        .error       (error),
        .coin_reject (coin_reject),
        .refund      (refund),
        .refund_amt  (refund_amt),
        .order_done  (order_done),
        .drink_out   (drink_out),
        .err_out     (err_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && valid === 1'b1) valid_seen++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic step(input logic cv, input int cval, input logic kv, input int kd,
                        input logic ok, input logic cn);
        coin_valid = cv;
        coin_value = PAY_W'(cval);
        key_valid  = kv;
        key_digit  = 4'(kd);
        key_ok     = ok;
        key_cancel = cn;
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        coin_value = '0;
        key_valid  = 1'b0;
        key_digit  = '0;
        key_ok     = 1'b0;
        key_cancel = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    // Full order against the reference: payment = min(sum of coins, MAX_PAY),
    // code = last two digits entered, error replaces the drink and refunds.
    task automatic run_order(input string name, input int coins[4], input int nc,
                             input int digits[4], input int nd, input int delay,
                             input int drk, input bit er);
        int exp_pay, exp_code, exp_drink, v0, n;
        exp_pay = 0;
        for (int i = 0; i < nc; i++) exp_pay += coins[i];
        if (exp_pay > MAX_PAY) exp_pay = MAX_PAY;
        exp_code  = digits[nd-2] * 16 + digits[nd-1];
        exp_drink = er ? 0 : drk;
        n = (nc > nd) ? nc : nd;
        for (int i = 0; i < n; i++)
            step(i < nc, (i < nc) ? coins[i] : 0, i < nd, (i < nd) ? digits[i] : 0, 0, 0);
        v0 = valid_seen;
        step(0, 0, 0, 0, 1, 0);
        checks++;
        if ({valid, busy, pay_in, code} !== {1'b1, 1'b1, PAY_W'(exp_pay), CODE_W'(exp_code)}) begin
            errors++;
            $display("FAIL %s issue: valid=%0b busy=%0b pay_in=%0d code=%h, expected valid=1 busy=1 pay_in=%0d code=%h",
                     name, valid, busy, pay_in, code, exp_pay, exp_code);
        end
        for (int d = 0; d < delay; d++) begin
            idle();
            checks++;
            if ({valid, order_done, pay_in, code} !== {1'b0, 1'b0, PAY_W'(exp_pay), CODE_W'(exp_code)}) begin
                errors++;
                $display("FAIL %s wait%0d: valid=%0b done=%0b pay_in=%0d code=%h, expected 0 0 %0d %h",
                         name, d, valid, order_done, pay_in, code, exp_pay, exp_code);
            end
        end
        drink = CODE_W'(drk);
        error = er;
        idle();
        drink = '0;
        error = 1'b0;
        checks++;
        if ({order_done, err_out, drink_out, refund, refund_amt, busy, pay_in} !==
            {1'b1, er, CODE_W'(exp_drink), er, er ? PAY_W'(exp_pay) : PAY_W'(0), 1'b0, PAY_W'(0)}) begin
            errors++;
            $display("FAIL %s result: done=%0b err=%0b drink=%h refund=%0b amt=%0d busy=%0b pay_in=%0d, expected 1 %0b %h %0b %0d 0 0",
                     name, order_done, err_out, drink_out, refund, refund_amt, busy, pay_in,
                     er, exp_drink, er, er ? exp_pay : 0);
        end
        idle();
        checks++;
        if ({order_done, refund, refund_amt, err_out, drink_out} !== {1'b0, 1'b0, PAY_W'(0), er, CODE_W'(exp_drink)}
            || (valid_seen - v0) != 1) begin
            errors++;
            $display("FAIL %s after: done=%0b refund=%0b amt=%0d err=%0b drink=%h valid_pulses=%0d, expected 0 0 0 %0b %h 1",
                     name, order_done, refund, refund_amt, err_out, drink_out, valid_seen - v0, er, exp_drink);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({valid, pay_in, code, coin_reject, refund, refund_amt, order_done, drink_out, err_out, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b pay_in=%0d code=%h rej=%0b refund=%0b amt=%0d done=%0b drink=%h err=%0b busy=%0b, expected all 0",
                     valid, pay_in, code, coin_reject, refund, refund_amt, order_done, drink_out, err_out, busy);
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_basic_order();
        run_order("basic", '{100, 200, 50, 0}, 3, '{1, 2, 0, 0}, 2, 3, 8'h12, 1'b0);
    endtask

    task automatic test_error_refund();
        run_order("error", '{500, 0, 0, 0}, 1, '{3, 4, 0, 0}, 2, 1, 0, 1'b1);
        run_order("error_wins", '{40, 0, 0, 0}, 1, '{9, 9, 0, 0}, 2, 2, 8'h55, 1'b1);
    endtask

    task automatic test_saturation();
        run_order("saturate", '{700, 700, 0, 0}, 2, '{1, 2, 3, 0}, 3, 2, 8'h23, 1'b0);
    endtask

    task automatic test_cancel();
        int v0;
        v0 = valid_seen;
        step(1, 200, 0, 0, 0, 0);
        step(0, 0, 1, 5, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ok_one_digit: valid=%0b busy=%0b, expected 0 0", valid, busy);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if ({refund, refund_amt} !== {1'b1, PAY_W'(200)}) begin
            errors++;
            $display("FAIL cancel_refund: refund=%0b amt=%0d, expected 1 200", refund, refund_amt);
        end
        idle();
        checks++;
        if ({refund, refund_amt} !== {1'b0, PAY_W'(0)}) begin
            errors++;
            $display("FAIL refund_pulse_end: refund=%0b amt=%0d, expected 0 0", refund, refund_amt);
        end
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ok_zero_acc: valid=%0b busy=%0b, expected 0 0", valid, busy);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (refund !== 1'b0) begin
            errors++;
            $display("FAIL cancel_zero_acc: refund=%0b, expected 0", refund);
        end
        step(1, 300, 1, 1, 0, 0);
        step(0, 0, 1, 2, 0, 0);
        step(1, 50, 0, 0, 1, 1);
        checks++;
        if ({refund, refund_amt, valid} !== {1'b1, PAY_W'(300), 1'b0} || valid_seen != v0) begin
            errors++;
            $display("FAIL cancel_wins: refund=%0b amt=%0d valid=%0b pulses=%0d, expected 1 300 0 0",
                     refund, refund_amt, valid, valid_seen - v0);
        end
        idle();
        run_order("after_cancel", '{10, 0, 0, 0}, 1, '{4, 5, 0, 0}, 2, 2, 8'h45, 1'b0);
    endtask

    task automatic test_reject_and_reset();
        step(1, 100, 1, 7, 0, 0);
        step(0, 0, 1, 8, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle();
        step(1, 100, 0, 0, 0, 0);
        checks++;
        if ({coin_reject, pay_in, busy} !== {1'b1, PAY_W'(100), 1'b1}) begin
            errors++;
            $display("FAIL coin_reject: rej=%0b pay_in=%0d busy=%0b, expected 1 100 1", coin_reject, pay_in, busy);
        end
        idle();
        checks++;
        if ({coin_reject, pay_in, code} !== {1'b0, PAY_W'(100), 8'h78}) begin
            errors++;
            $display("FAIL reject_pulse_end: rej=%0b pay_in=%0d code=%h, expected 0 100 78", coin_reject, pay_in, code);
        end
        rst = 1'b1;
        idle();
        checks++;
        if ({valid, pay_in, code, coin_reject, refund, refund_amt, order_done, drink_out, err_out, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: valid=%0b pay_in=%0d code=%h rej=%0b refund=%0b amt=%0d done=%0b drink=%h err=%0b busy=%0b, expected all 0",
                     valid, pay_in, code, coin_reject, refund, refund_amt, order_done, drink_out, err_out, busy);
        end
        rst = 1'b0;
        idle();
        checks++;
        if ({refund, busy, order_done} !== 3'b000) begin
            errors++;
            $display("FAIL no_refund_after_reset: refund=%0b busy=%0b done=%0b, expected 0 0 0", refund, busy, order_done);
        end
    endtask

    task automatic test_random();
        int coins[4], digits[4];
        int nc, nd, dly, drk;
        bit er;
        for (int it = 0; it < 25; it++) begin
            nc = $urandom_range(1, 4);
            nd = $urandom_range(2, 4);
            for (int i = 0; i < 4; i++) begin
                coins[i]  = $urandom_range(1, 600);
                digits[i] = $urandom_range(0, 15);
            end
            er  = ($urandom_range(0, 3) == 0);
            drk = er ? $urandom_range(0, 255) : $urandom_range(1, 255);
            dly = $urandom_range(1, 6);
            run_order($sformatf("random%0d", it), coins, nc, digits, nd, dly, drk, er);
        end
    endtask

`ifdef DR_RSP_TIMEOUT_EN
    task automatic test_timeout();
        step(1, 333, 1, 9, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (RSP_TIMEOUT) idle();
        checks++;
        if ({busy, order_done} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_not_yet: busy=%0b done=%0b, expected 1 0", busy, order_done);
        end
        idle();
        checks++;
        if ({order_done, err_out, drink_out, refund, refund_amt} !== {1'b1, 1'b1, 8'h00, 1'b1, PAY_W'(333)}) begin
            errors++;
            $display("FAIL timeout: done=%0b err=%0b drink=%h refund=%0b amt=%0d, expected 1 1 00 1 333",
                     order_done, err_out, drink_out, refund, refund_amt);
        end
        idle();
        step(1, 44, 1, 2, 0, 0);
        step(0, 0, 1, 3, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (RSP_TIMEOUT) idle();
        drink = 8'h23;
        idle();
        drink = '0;
        checks++;
        if ({order_done, err_out, drink_out, refund} !== {1'b1, 1'b0, 8'h23, 1'b0}) begin
            errors++;
            $display("FAIL rsp_last_cycle: done=%0b err=%0b drink=%h refund=%0b, expected 1 0 23 0",
                     order_done, err_out, drink_out, refund);
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_order();
        test_error_refund();
        test_saturation();
        test_cancel();
        test_reject_and_reset();
        test_random();
`ifdef DR_RSP_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
